restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 8 +
 rtl/add_sub9.sv | 18 +
 rtl/restoring_divider.sv | 106 ++++++++++
 tb/tb_restoring_divider.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg: shared width default, FSM state encoding and counter sizing.
package restoring_divider_pkg;
    localparam int WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/add_sub9.sv
// add_sub9: N-bit ripple-carry adder built from full-adder cells; subtraction by feeding ~y and cin=1.
module add_sub9 #(
    parameter int N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] z,
    output logic         cout
);
    logic [N:0] w_c;
    assign w_c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign z[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
    assign cout = w_c[N];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per cycle.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_state_nx;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q, r_m, r_quot, r_rem;
    logic [CW-1:0]    r_cnt, w_cnt_inc;
    logic             r_dbz;
    logic [WIDTH:0]   w_a_sh, w_sum, w_a_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_cout, w_neg, w_last, w_dz, w_unused;

    assign w_a_sh = {r_a[WIDTH-1:0], r_q[WIDTH-1]};

    add_sub9 #(.N(WIDTH + 1)) u_add (
        .x    (w_a_sh),
        .y    (~{1'b0, r_m}),
        .cin  (1'b1),
        .z    (w_sum),
        .cout (w_cout)
    );

    // A never exceeds the divisor after a step, so its top bit and the carry carry no extra information
    assign w_unused = ^{r_a[WIDTH], w_cout};
    assign w_neg    = w_sum[WIDTH];
    assign w_a_nx   = w_neg ? w_a_sh : w_sum;
    assign w_q_nx   = {r_q[WIDTH-2:0], ~w_neg};
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_dz     = divisor == '0;

    for (genvar i = 0; i < CW; i++) begin : g_inc
        if (i == 0) begin : g_lsb
            assign w_cnt_inc[i] = ~r_cnt[i];
        end else begin : g_bit
            assign w_cnt_inc[i] = r_cnt[i] ^ (&r_cnt[i-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = start ? (w_dz ? DONE : RUN) : IDLE;
            RUN:     w_state_nx = w_last ? DONE : RUN;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            if (w_dz) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_a   <= '0;
                r_q   <= dividend;
                r_m   <= divisor;
                r_cnt <= '0;
            end
        end else if (r_state == RUN) begin
            r_a   <= w_a_nx;
            r_q   <= w_q_nx;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
                r_quot <= w_q_nx;
                r_rem  <= w_a_nx[WIDTH-1:0];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign busy        = r_state == RUN;
    assign done        = r_state == DONE;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and random checks of restoring_divider against an arithmetic model.
module tb_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.z = b == 0;
        e.q = b == 0 ? 8'hff : 8'(a / b);
        e.r = b == 0 ? 8'(a) : 8'(a % b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("expected_done", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.z));
                chk("busy_in_done", int'(busy), 0);
            end
        end
    end

    // Starts a division at a falling edge and counts rising edges until done is seen
    task automatic run_div(input int a, input int b, output int lat, output int bc);
        @(negedge clk);
        dividend = 8'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        bc  = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_single_pulse", int'(done), 0);
    endtask

    initial begin
        int lat, bc, first;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(quotient), 0);
        chk("reset_r", int'(remainder), 0);
        rst_n = 1'b1;

        e = model(100, 7);
        chk("model_100_7_q", int'(e.q), 14);
        chk("model_100_7_r", int'(e.r), 2);
        e = model(200, 0);
        chk("model_200_0_q", int'(e.q), 255);

        run_div(100, 7, lat, bc);
        chk("lit_100_7_q", int'(quotient), 14);
        chk("lit_100_7_r", int'(remainder), 2);
        chk("lit_100_7_dbz", int'(div_by_zero), 0);
        chk("latency_100_7", lat, 9);
        chk("busy_cycles_100_7", bc, 8);

        run_div(255, 1, lat, bc);
        chk("lit_255_1_q", int'(quotient), 255);
        chk("lit_255_1_r", int'(remainder), 0);
        run_div(5, 9, lat, bc);
        chk("lit_5_9_q", int'(quotient), 0);
        chk("lit_5_9_r", int'(remainder), 5);

        run_div(200, 0, lat, bc);
        chk("lit_200_0_q", int'(quotient), 255);
        chk("lit_200_0_r", int'(remainder), 200);
        chk("lit_200_0_dbz", int'(div_by_zero), 1);
        chk("latency_200_0", lat, 1);
        chk("busy_cycles_200_0", bc, 0);

        // second request during RUN must be dropped
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        exp_q.push_back(model(100, 7));
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                dividend = 8'd50;
                divisor  = 8'd5;
                start    = 1'b1;
            end
            if (n == 4) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("ignored_start_latency", lat, 9);
        chk("ignored_start_q", int'(quotient), 14);
        chk("ignored_start_r", int'(remainder), 2);
        repeat (15) @(negedge clk);
        chk("ignored_start_no_run", exp_q.size(), 0);
        chk("ignored_start_hold_q", int'(quotient), 14);

        // start held high: back-to-back with one idle cycle between
        dividend = 8'd20;
        divisor  = 8'd3;
        start    = 1'b1;
        exp_q.push_back(model(20, 3));
        exp_q.push_back(model(20, 3));
        first = 0;
        lat   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done && first == 0) first = n;
            else if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("b2b_first_latency", first, 9);
        chk("b2b_second_gap", lat - first, 10);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-division
        dividend = 8'd255;
        divisor  = 8'd3;
        start    = 1'b1;
        exp_q.push_back(model(255, 3));
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_div(9, 2, lat, bc);
        chk("post_reset_q", int'(quotient), 4);
        chk("post_reset_r", int'(remainder), 1);
        chk("post_reset_latency", lat, 9);

        for (int i = 0; i < 512; i++) begin
            run_div(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), lat, bc);
            if (lat != (divisor == 0 ? 1 : 9)) chk("random_latency", lat, divisor == 0 ? 1 : 9);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
